// File: rtl/xpb_pkg.sv
// Shared constants and FSM encoding for the xpb reduction-table generator.
package xpb_pkg;

    localparam int unsigned XPB_SEG_BITS = 5;
    localparam int unsigned XPB_DEPTH    = 2 ** XPB_SEG_BITS;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPow  = 2'd1,
        StGen  = 2'd2,
        StErr  = 2'd3
    } xpb_state_e;

endpackage

// File: rtl/mod_add_cond_sub.sv
// One combinational modular-add step: (a + b) mod m, valid when a, b < m.
module mod_add_cond_sub #(
    parameter int unsigned WIDTH = 1024
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH:0] sum_full;
    logic           ge_m;

    // The compare needs the carry bit; the subtract can wrap in WIDTH bits since the
    // true result is below m.
    always_comb begin
        sum_full = {1'b0, a_i} + {1'b0, b_i};
        ge_m     = (sum_full >= {1'b0, m_i});
        sum_o    = sum_full[WIDTH-1:0] - (ge_m ? m_i : '0);
    end

endmodule

// File: rtl/xpb_table_gen.sv
// Run-time xpb table generator: base = 2^shift_amt mod M, then streams k*base mod M
// for k = 0 .. 2^SEG_BITS-1 over a valid/ready write port.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int unsigned WIDTH    = 1024,
    parameter int unsigned SEG_BITS = XPB_SEG_BITS,
    parameter int unsigned SHIFT_W  = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    modulus,
    input  logic [SHIFT_W-1:0]  shift_amt,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [SEG_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]    wr_data
);

    xpb_state_e          state_q, state_d;
    logic [WIDTH-1:0]    mod_q, mod_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    base_q, base_d;
    logic [SHIFT_W-1:0]  cnt_q, cnt_d;
    logic [SEG_BITS-1:0] k_q, k_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_valid_q, wr_valid_d;

    logic [WIDTH-1:0]    add_b;
    logic [WIDTH-1:0]    add_sum;

    // Single adder: doubling in POW, accumulate base in GEN.
    assign add_b = (state_q == StGen) ? base_q : acc_q;

    mod_add_cond_sub #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (add_b),
        .m_i   (mod_q),
        .sum_o (add_sum)
    );

    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        acc_d      = acc_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_valid_d = wr_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mod_d  = modulus;
                    cnt_d  = shift_amt;
                    busy_d = 1'b1;
                    if (modulus == '0) begin
                        state_d = StErr;
                    end else begin
                        // 2^0 mod 1 is 0, keeping acc < M from the start.
                        acc_d   = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state_d = StPow;
                    end
                end
            end
            StErr: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StPow: begin
                if (cnt_q != '0) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q - SHIFT_W'(1);
                end else begin
                    base_d     = acc_q;
                    acc_d      = '0;
                    k_d        = '0;
                    wr_valid_d = 1'b1;
                    state_d    = StGen;
                end
            end
            StGen: begin
                if (wr_ready) begin
                    acc_d = add_sum;
                    k_d   = k_q + SEG_BITS'(1);
                    if (k_q == '1) begin
                        wr_valid_d = 1'b0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mod_q      <= '0;
            acc_q      <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mod_q      <= mod_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = k_q;
    assign wr_data  = acc_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard bench for xpb_table_gen: a 16-bit instance for protocol/corner cases and a
// 1024-bit instance checked against wide-arithmetic golden values.
module tb_xpb_table_gen;
    import xpb_pkg::*;

    typedef struct packed {
        logic [4:0]    addr;
        logic [1023:0] data;
    } entry_t;

    logic clk;
    logic reset;

    logic        start16, busy16, done16, err16, wr_valid16, wr_ready16;
    logic [15:0] mod16, wr_data16;
    logic [11:0] shift16;
    logic [4:0]  wr_addr16;

    logic          start1k, busy1k, done1k, err1k, wr_valid1k, wr_ready1k;
    logic [1023:0] mod1k, wr_data1k;
    logic [11:0]   shift1k;
    logic [4:0]    wr_addr1k;

    int n_checks = 0;
    int n_fail   = 0;
    bit ready_rnd = 1'b0;

    entry_t sb16[$];
    entry_t sb1k[$];
    entry_t ent16, ent1k;

    logic        prev_valid16, prev_hs16;
    logic [4:0]  prev_addr16;
    logic [15:0] prev_data16;

    xpb_table_gen #(
        .WIDTH    (16),
        .SEG_BITS (5),
        .SHIFT_W  (12)
    ) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .start     (start16),
        .modulus   (mod16),
        .shift_amt (shift16),
        .busy      (busy16),
        .done      (done16),
        .err       (err16),
        .wr_valid  (wr_valid16),
        .wr_ready  (wr_ready16),
        .wr_addr   (wr_addr16),
        .wr_data   (wr_data16)
    );

    xpb_table_gen #(
        .WIDTH    (1024),
        .SEG_BITS (5),
        .SHIFT_W  (12)
    ) u_dut1k (
        .clk       (clk),
        .reset     (reset),
        .start     (start1k),
        .modulus   (mod1k),
        .shift_amt (shift1k),
        .busy      (busy1k),
        .done      (done1k),
        .err       (err1k),
        .wr_valid  (wr_valid1k),
        .wr_ready  (wr_ready1k),
        .wr_addr   (wr_addr1k),
        .wr_data   (wr_data1k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink ready: tied high or a 50% coin flip, changed just after each rising edge.
    initial begin
        wr_ready16 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wr_ready16 = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_valid16 <= 1'b0;
            prev_hs16    <= 1'b0;
        end else begin
            if (prev_valid16 && !prev_hs16) begin
                check("hold_valid16", wr_valid16, 1'b1);
                check("hold_addr16", wr_addr16, prev_addr16);
                check("hold_data16", wr_data16, prev_data16);
            end
            if (wr_valid16 && wr_ready16) begin
                check("extra_wr16", sb16.size() > 0, 1'b1);
                if (sb16.size() > 0) begin
                    ent16 = sb16.pop_front();
                    check("addr16", wr_addr16, ent16.addr);
                    check("data16", wr_data16, ent16.data);
                end
            end
            prev_valid16 <= wr_valid16;
            prev_hs16    <= wr_valid16 && wr_ready16;
            prev_addr16  <= wr_addr16;
            prev_data16  <= wr_data16;
        end
    end

    always @(negedge clk) begin
        if (!reset && wr_valid1k && wr_ready1k) begin
            check("extra_wr1k", sb1k.size() > 0, 1'b1);
            if (sb1k.size() > 0) begin
                ent1k = sb1k.pop_front();
                check("addr1k", wr_addr1k, ent1k.addr);
                check("data1k", wr_data1k, ent1k.data);
            end
        end
    end

    // Latencies are counted in rising edges after the edge that samples start.
    task automatic run16(input logic [15:0] m, input logic [11:0] s, input bit rnd,
                         input bit poke);
        logic [63:0] p, b, e;
        int first_v, done_n;
        logic got_err;
        ready_rnd = rnd;
        if (m != 16'd0) begin
            p = 64'd1 << s;
            b = p % {48'd0, m};
            for (int k = 0; k < XPB_DEPTH; k++) begin
                e = (64'(k) * b) % {48'd0, m};
                sb16.push_back({5'(k), 1024'(e)});
            end
        end
        @(posedge clk);
        #1;
        start16 = 1'b1;
        mod16   = m;
        shift16 = s;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        first_v = -1;
        done_n  = -1;
        got_err = 1'b0;
        for (int n = 0; n < 600 && done_n < 0; n++) begin
            @(negedge clk);
            if (n == 0) check("busy16", busy16, 1'b1);
            if (wr_valid16 && first_v < 0) first_v = n;
            if (done16) begin
                done_n  = n;
                got_err = err16;
            end
            if (poke && n == int'(s) + 6) begin
                start16 = 1'b1;
                mod16   = 16'h1234;
                shift16 = 12'd3;
                @(posedge clk);
                #1;
                start16 = 1'b0;
            end
        end
        check("done_seen16", done_n >= 0, 1'b1);
        check("err16", got_err, m == 16'd0);
        if (m == 16'd0) begin
            check("no_valid_err16", first_v < 0, 1'b1);
            check("err_lat16", done_n, 1);
        end else if (!rnd) begin
            check("first_valid_lat16", first_v, int'(s) + 1);
            check("done_lat16", done_n, int'(s) + 1 + XPB_DEPTH);
        end
        check("sb_drained16", sb16.size(), 0);
        @(negedge clk);
        check("done_pulse16", done16, 1'b0);
        check("idle_busy16", busy16, 1'b0);
        check("idle_valid16", wr_valid16, 1'b0);
        ready_rnd = 1'b0;
    endtask

    initial begin
        logic [2047:0] p, b, e, m_ext;
        int done_n;
        bit saw_done;

        reset   = 1'b1;
        start16 = 1'b0;
        mod16   = '0;
        shift16 = '0;
        start1k = 1'b0;
        mod1k   = '0;
        shift1k = '0;
        wr_ready1k = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy16", busy16, 1'b0);
        check("rst_done16", done16, 1'b0);
        check("rst_err16", err16, 1'b0);
        check("rst_valid16", wr_valid16, 1'b0);
        check("rst_addr16", wr_addr16, 5'd0);
        check("rst_data16", wr_data16, 16'd0);
        check("rst_data1k", wr_data1k, 1024'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run16(16'hFFF1, 12'd20, 1'b0, 1'b0);
        run16(16'hFFF1, 12'd0, 1'b0, 1'b0);
        run16(16'hFFF1, 12'd20, 1'b1, 1'b0);
        run16(16'h0000, 12'd7, 1'b0, 1'b0);
        run16(16'h0001, 12'd5, 1'b0, 1'b0);
        run16(16'hFFF1, 12'd20, 1'b0, 1'b1);
        run16(16'hA001, 12'd37, 1'b1, 1'b0);

        // Abort mid-POW: outputs clear at once and the run never completes.
        @(posedge clk);
        #1;
        start16 = 1'b1;
        mod16   = 16'hFFF1;
        shift16 = 12'd20;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy16", busy16, 1'b0);
        check("abort_done16", done16, 1'b0);
        check("abort_valid16", wr_valid16, 1'b0);
        check("abort_data16", wr_data16, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done16 || wr_valid16 || busy16) saw_done = 1'b1;
        end
        check("abort_quiet16", saw_done, 1'b0);
        run16(16'hFFF1, 12'd20, 1'b0, 1'b0);

        // Wide run; top bit of M set so doubling exercises the carry into bit WIDTH.
        mod1k = {8{128'hC90FDAA22168C234C4C6628B80DC1CD1}};
        m_ext = {1024'd0, mod1k};
        p = 2048'd1 << 875;
        b = p % m_ext;
        for (int k = 0; k < XPB_DEPTH; k++) begin
            e = (2048'(k) * b) % m_ext;
            sb1k.push_back({5'(k), e[1023:0]});
        end
        @(posedge clk);
        #1;
        start1k = 1'b1;
        shift1k = 12'd875;
        @(posedge clk);
        #1;
        start1k = 1'b0;
        done_n = -1;
        for (int n = 0; n < 1500 && done_n < 0; n++) begin
            @(negedge clk);
            if (done1k) begin
                done_n = n;
                check("err1k", err1k, 1'b0);
            end
        end
        check("done_lat1k", done_n, 875 + 1 + XPB_DEPTH);
        check("sb_drained1k", sb1k.size(), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
